oam_dma_engine: RTL and testbench
=================================

// Module: oam_dma_engine
// PURPOSE
//  OAM DMA controller: responder on the MMIO DMA register (0xFF46) and initiator on the DMA bus port.
//  A CPU write of value XX to 0xFF46 copies 160 bytes from XX00-XX9F into OAM at FE00-FE9F.
//  It moves one byte per slot through the MMU's dma_req port.
//  The MMU sees addr 0xFFFF on that port as "no DMA". While the address is anything else, CPU access to OAM is blocked.
// PARAMETERS
//  CYCLES_PER_BYTE  4   clk cycles per byte slot (one M-cycle); must be >= READ_LAT+2
//  READ_LAT         1   clocks from first source-address presentation to read_out valid
// PORTS
//  clk                       in   1   system clock
//  rst                       in   1   synchronous, active-high reset
//  mmio_dma_if.addr_select   in   16  MMIO address from MMU (0xFF46 when selected)
//  mmio_dma_if.write_value   in   8   source page high byte
//  mmio_dma_if.write_enable  in   1   MMIO write strobe
//  mmio_dma_if.read_out      out  8   readback of DMA register
//  dma_req.addr_select       out  16  bus address; 16'hFFFF = idle
//  dma_req.write_value       out  8   byte written to OAM
//  dma_req.write_enable      out  1   OAM write strobe
//  dma_req.read_out          in   8   source byte returned by MMU
//  dma_active                out  1   high from trigger until the last byte is written
// BEHAVIOUR
//  - Interfaces are mem_if modports: mmio_dma_if is slave, dma_req is master. All dma_req outputs and dma_active are registered.
//  - Reset: dma_req.addr_select=16'hFFFF, write_value=0, write_enable=0, dma_active=0, src_hi=8'hFF. Reset wins over any pending trigger.
//  - Register: mmio_dma_if.read_out = src_hi at all times.
//  - Trigger: write_enable && addr_select==16'hFF46. Latch src_hi<=write_value, idx<=0, enter START.
//    Writes to any other address are ignored.
//  - Source fold: if src_hi >= 8'hE0, source high = src_hi-8'h20, so E0-FF maps to C0-DF.
//    src addr = {fold(src_hi), idx}; dst addr = 16'hFE00 + idx. idx is 8-bit and runs 0..159.
//  - FSM IDLE -> START -> XFER -> IDLE.
//    IDLE: addr=FFFF, we=0, dma_active=0.
//    START: lasts CYCLES_PER_BYTE clocks; addr=FFFF, we=0, dma_active=1.
//    XFER: phase counter ph runs 0..CYCLES_PER_BYTE-1 per byte. Phase rules are in terms of the values on the bus in that cycle:
//      ph 0..READ_LAT: addr=src, we=0; capture dma_req.read_out in the ph==READ_LAT cycle.
//      ph READ_LAT+1: addr=dst, write_value=captured byte, we=1 for exactly one clock.
//      ph > READ_LAT+1: addr=dst, we=0.
//      At ph wrap: idx+1. After idx 159 is written: IDLE, so addr=FFFF and dma_active=0 on the next slot boundary.
//  - Latency: first OAM write occurs CYCLES_PER_BYTE+READ_LAT+1 clocks after the trigger cycle.
//    Whole transfer = (160+1)*CYCLES_PER_BYTE clocks.
//  - Retrigger during START or XFER: restart at START with idx=0 and the new src_hi.
//    A write strobe already on the bus in the trigger cycle completes; no later write for the old transfer is issued.
//  - Retrigger in the same cycle as the final write: final write completes, then START.
//  - dma_req.read_out is ignored outside capture cycles.
// STRUCTURE
//  - Shared package gb_mem_pkg:
//    DMA_REG_ADDR=16'hFF46, OAM_BASE=16'hFE00, OAM_BYTES=160, BUS_IDLE_ADDR=16'hFFFF,
//    typedef enum {DMA_IDLE, DMA_START, DMA_XFER} dma_state_t.
//  - Single module; phase counter, idx counter and FSM are inline, with no sub-module.
// TESTING (defaults; MMU + WRAM model with 1-clock read latency)
//  1. rst held 2 clks -> addr=FFFF, we=0, dma_active=0, mmio read_out=FF.
//  2. WRAM C100+i = i^8'h5A; write C1 to FF46 -> 160 we pulses, 4 clks apart, FE00+i gets i^5A;
//     first pulse 6 clks after trigger; addr=FFFF at clk 644.
//  3. Write FE to FF46 -> source reads DE00-DE9F; read_out=FE.
//  4. Write C1, then write C2 during byte 80 -> no write to FE50+ from C1; new sequence from FE00 with C200 data.
//  5. rst asserted during byte 50 -> next clk addr=FFFF, we=0, no further OAM writes.
//  6. Write 0x33 at FF47 -> no transfer, read_out unchanged; CPU OAM write succeeds only while dma addr==FFFF.

Source files
------------

// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and types for the Game Boy memory subsystem.
package gb_mem_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam logic [15:0] BUS_IDLE_ADDR = 16'hFFFF;
    localparam int          OAM_BYTES     = 160;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_XFER
    } dma_state_t;

    // Echo RAM pages E0-FF alias the work RAM at C0-DF.
    function automatic logic [7:0] fold_src_page(input logic [7:0] hi);
        return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
    endfunction

endpackage

// File: rtl/mem_if.sv
// Byte-wide memory access port shared between MMU, CPU and DMA.
interface mem_if;
    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (output addr_select, output write_value, output write_enable, input read_out);
    modport slave  (input addr_select, input write_value, input write_enable, output read_out);
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA: copies 160 bytes from page {src_hi,00} into FE00-FE9F, one byte per slot.
// Latency: first OAM write strobe CYCLES_PER_BYTE+READ_LAT+1 clocks after the trigger cycle.
// Backpressure: none; the MMU must serve a read every slot, and a retrigger restarts the copy.
module oam_dma_engine
    import gb_mem_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int READ_LAT        = 1
) (
    input  logic  clk,
    input  logic  rst,
    mem_if.slave  mmio_dma_if,
    mem_if.master dma_req,
    output logic  dma_active
);

    localparam int PW = $clog2(CYCLES_PER_BYTE);
    localparam logic [PW-1:0] PH_CAP   = PW'(READ_LAT);
    localparam logic [PW-1:0] PH_WR    = PW'(READ_LAT + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]    LAST_IDX = 8'(OAM_BYTES - 1);

    dma_state_t    state;
    logic [PW-1:0] ph;
    logic [PW-1:0] start_cnt;
    logic [7:0]    idx;
    logic [7:0]    src_hi;
    logic [15:0]   bus_addr;
    logic [7:0]    bus_wdat;
    logic          bus_we;

    logic          trigger;
    logic          ph_last;
    logic [PW-1:0] nxt_ph;
    logic [7:0]    nxt_idx;
    logic [7:0]    src_page;

    assign trigger = mmio_dma_if.write_enable && (mmio_dma_if.addr_select == DMA_REG_ADDR);

    always_comb begin
        ph_last  = (ph == PH_LAST);
        nxt_ph   = ph_last ? '0 : ph + PW'(1);
        nxt_idx  = ph_last ? idx + 8'd1 : idx;
        src_page = fold_src_page(src_hi);
    end

    // Bus outputs are computed for the cycle after the edge, so they leave a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DMA_IDLE;
            ph         <= '0;
            start_cnt  <= '0;
            idx        <= '0;
            src_hi     <= 8'hFF;
            bus_addr   <= BUS_IDLE_ADDR;
            bus_wdat   <= 8'h00;
            bus_we     <= 1'b0;
            dma_active <= 1'b0;
        end else if (trigger) begin
            // The trigger cycle counts as the first START clock.
            state      <= DMA_START;
            src_hi     <= mmio_dma_if.write_value;
            idx        <= '0;
            ph         <= '0;
            start_cnt  <= PW'(1);
            bus_addr   <= BUS_IDLE_ADDR;
            bus_we     <= 1'b0;
            dma_active <= 1'b1;
        end else begin
            case (state)
                DMA_START: begin
                    if (start_cnt == PH_LAST) begin
                        state    <= DMA_XFER;
                        ph       <= '0;
                        bus_addr <= {src_page, idx};
                    end else begin
                        start_cnt <= start_cnt + PW'(1);
                    end
                end
                DMA_XFER: begin
                    if (ph == PH_CAP) begin
                        bus_wdat <= dma_req.read_out;
                    end
                    ph <= nxt_ph;
                    if (ph_last && (idx == LAST_IDX)) begin
                        state      <= DMA_IDLE;
                        bus_addr   <= BUS_IDLE_ADDR;
                        bus_we     <= 1'b0;
                        dma_active <= 1'b0;
                    end else begin
                        idx <= nxt_idx;
                        if (nxt_ph <= PH_CAP) begin
                            bus_addr <= {src_page, nxt_idx};
                            bus_we   <= 1'b0;
                        end else begin
                            bus_addr <= OAM_BASE + {8'h00, nxt_idx};
                            bus_we   <= (nxt_ph == PH_WR);
                        end
                    end
                end
                default: begin
                    bus_addr   <= BUS_IDLE_ADDR;
                    bus_we     <= 1'b0;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

    assign mmio_dma_if.read_out = src_hi;
    assign dma_req.addr_select  = bus_addr;
    assign dma_req.write_value  = bus_wdat;
    assign dma_req.write_enable = bus_we;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine with an MMU/WRAM model (1-clock registered read) and an OAM array.
module tb_oam_dma_engine;

    logic clk = 1'b0;
    logic rst;
    logic dma_active;
    always #5 clk = ~clk;

    mem_if mmio ();
    mem_if dma ();

    oam_dma_engine #(.CYCLES_PER_BYTE(4), .READ_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .mmio_dma_if (mmio),
        .dma_req     (dma),
        .dma_active  (dma_active)
    );

    logic [7:0]  wram [65536];
    logic [7:0]  oam  [160];
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;

    int cyc;
    int trig_cyc;
    int n_chk;
    int n_fail;

    logic [15:0] log_addr [$];
    logic [7:0]  log_dat  [$];
    int          log_cyc  [$];

    // MMU model: registered WRAM read, OAM writes from DMA or from CPU when the DMA port is idle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        dma.read_out <= wram[dma.addr_select];
        if (dma.write_enable && dma.addr_select >= 16'hFE00 && dma.addr_select < 16'hFEA0)
            oam[dma.addr_select[7:0]] <= dma.write_value;
        else if (cpu_we && dma.addr_select == 16'hFFFF && cpu_addr >= 16'hFE00 && cpu_addr < 16'hFEA0)
            oam[cpu_addr[7:0]] <= cpu_dat;
    end

    always @(negedge clk) begin
        if (dma.write_enable) begin
            log_addr.push_back(dma.addr_select);
            log_dat.push_back(dma.write_value);
            log_cyc.push_back(cyc);
        end
    end

    typedef struct {
        int          k;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdat;
        logic        act;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        mmio.addr_select  = a;
        mmio.write_value  = v;
        mmio.write_enable = 1'b1;
        trig_cyc = cyc;
        @(negedge clk);
        mmio.write_enable = 1'b0;
        mmio.addr_select  = 16'h0000;
    endtask

    task automatic wait_k(input int t0, input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    task automatic wait_idle(input string nm, input int max);
        int n = 0;
        while (dma_active && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(dma_active), 0);
    endtask

    task automatic cpu_oam_write(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = a; cpu_dat = v;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    initial begin
        int base, t0, err, gap_err;
        for (int i = 0; i < 65536; i++) wram[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            wram[16'hC100 + i] = 8'(i) ^ 8'h5A;
            wram[16'hDE00 + i] = 8'(i) ^ 8'hA5;
            wram[16'hC200 + i] = 8'(i) + 8'h03;
        end
        rst = 1'b1;
        mmio.addr_select = 16'h0000; mmio.write_value = 8'h00; mmio.write_enable = 1'b0;
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_dat = 8'h00;

        // 1. Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst addr", int'(dma.addr_select), 16'hFFFF);
        chk("rst we", int'(dma.write_enable), 0);
        chk("rst active", int'(dma_active), 0);
        chk("rst read_out", int'(mmio.read_out), 8'hFF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 2. Full transfer from C100: bus snapshots at cycle offsets from the trigger cycle
        vecs[0]  = '{1,   16'hFFFF, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{3,   16'hFFFF, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{4,   16'hC100, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{5,   16'hC100, 1'b0, 8'h00, 1'b1};
        vecs[4]  = '{6,   16'hFE00, 1'b1, 8'h5A, 1'b1};
        vecs[5]  = '{7,   16'hFE00, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{8,   16'hC101, 1'b0, 8'h00, 1'b1};
        vecs[7]  = '{10,  16'hFE01, 1'b1, 8'h5B, 1'b1};
        vecs[8]  = '{640, 16'hC19F, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{642, 16'hFE9F, 1'b1, 8'hC5, 1'b1};
        vecs[10] = '{643, 16'hFE9F, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{644, 16'hFFFF, 1'b0, 8'h00, 1'b0};
        base = log_addr.size();
        cpu_write(16'hFF46, 8'hC1);
        t0 = trig_cyc;
        for (int i = 0; i < 12; i++) begin
            wait_k(t0, vecs[i].k);
            chk($sformatf("t2 addr k=%0d", vecs[i].k), int'(dma.addr_select), int'(vecs[i].addr));
            chk($sformatf("t2 we k=%0d", vecs[i].k), int'(dma.write_enable), int'(vecs[i].we));
            chk($sformatf("t2 active k=%0d", vecs[i].k), int'(dma_active), int'(vecs[i].act));
            if (vecs[i].we)
                chk($sformatf("t2 wdat k=%0d", vecs[i].k), int'(dma.write_value), int'(vecs[i].wdat));
        end
        chk("t2 pulse count", log_addr.size() - base, 160);
        err = 0; gap_err = 0;
        for (int i = 0; i < 160 && base + i < log_addr.size(); i++) begin
            if (log_addr[base+i] != 16'hFE00 + 16'(i) || log_dat[base+i] != (8'(i) ^ 8'h5A)) err++;
            if (i > 0 && log_cyc[base+i] - log_cyc[base+i-1] != 4) gap_err++;
        end
        chk("t2 data errors", err, 0);
        chk("t2 pulse gap errors", gap_err, 0);
        if (log_cyc.size() > base) chk("t2 first pulse offset", log_cyc[base] - t0, 6);
        chk("t2 read_out", int'(mmio.read_out), 8'hC1);

        // 3. Echo page FE reads DE00; retrigger with C2 in the final write cycle
        base = log_addr.size();
        cpu_write(16'hFF46, 8'hFE);
        t0 = trig_cyc;
        chk("t3 read_out FE", int'(mmio.read_out), 8'hFE);
        wait_k(t0, 4);
        chk("t3 src addr", int'(dma.addr_select), 16'hDE00);
        wait_k(t0, 641);
        cpu_write(16'hFF46, 8'hC2);
        chk("t3 restart active", int'(dma_active), 1);
        chk("t3 restart addr", int'(dma.addr_select), 16'hFFFF);
        wait_idle("t3 completion timeout", 800);
        chk("t3 pulse count", log_addr.size() - base, 320);
        err = 0;
        for (int i = 0; i < 160 && base + 160 + i < log_addr.size(); i++) begin
            if (log_addr[base+i] != 16'hFE00 + 16'(i) || log_dat[base+i] != (8'(i) ^ 8'hA5)) err++;
            if (log_addr[base+160+i] != 16'hFE00 + 16'(i) || log_dat[base+160+i] != 8'(i) + 8'h03) err++;
        end
        chk("t3 data errors", err, 0);
        chk("t3 read_out C2", int'(mmio.read_out), 8'hC2);

        // 4. Retrigger with C2 during byte 80 of a C1 transfer
        base = log_addr.size();
        cpu_write(16'hFF46, 8'hC1);
        t0 = trig_cyc;
        wait_k(t0, 324);
        chk("t4 byte80 src", int'(dma.addr_select), 16'hC150);
        cpu_write(16'hFF46, 8'hC2);
        wait_idle("t4 completion timeout", 800);
        chk("t4 pulse count", log_addr.size() - base, 240);
        err = 0;
        for (int i = 0; i < 240 && base + i < log_addr.size(); i++) begin
            if (i < 80) begin
                if (log_addr[base+i] != 16'hFE00 + 16'(i) || log_dat[base+i] != (8'(i) ^ 8'h5A)) err++;
            end else begin
                if (log_addr[base+i] != 16'hFE00 + 16'(i-80) || log_dat[base+i] != 8'(i-80) + 8'h03) err++;
            end
        end
        chk("t4 data errors", err, 0);

        // 5. Reset during byte 50
        base = log_addr.size();
        cpu_write(16'hFF46, 8'hC1);
        t0 = trig_cyc;
        wait_k(t0, 205);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 rst addr", int'(dma.addr_select), 16'hFFFF);
        chk("t5 rst we", int'(dma.write_enable), 0);
        chk("t5 rst active", int'(dma_active), 0);
        chk("t5 rst read_out", int'(mmio.read_out), 8'hFF);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5 pulse count", log_addr.size() - base, 50);
        chk("t5 idle addr", int'(dma.addr_select), 16'hFFFF);

        // 6. Write to FF47 is ignored; CPU OAM access only while the DMA port is idle
        base = log_addr.size();
        cpu_write(16'hFF47, 8'h33);
        repeat (3) @(negedge clk);
        chk("t6 read_out", int'(mmio.read_out), 8'hFF);
        chk("t6 active", int'(dma_active), 0);
        chk("t6 addr", int'(dma.addr_select), 16'hFFFF);
        chk("t6 no pulses", log_addr.size() - base, 0);
        cpu_oam_write(16'hFE10, 8'h77);
        chk("t6 cpu oam write", int'(oam[16]), 8'h77);
        cpu_write(16'hFF46, 8'hC1);
        t0 = trig_cyc;
        wait_k(t0, 8);
        cpu_oam_write(16'hFE9E, 8'hEE);
        chk("t6 blocked cpu write", int'(oam[158]), 8'hA1);
        wait_idle("t6 completion timeout", 800);
        chk("t6 oam FE9E", int'(oam[158]), 8'hC4);
        chk("t6 oam FE10", int'(oam[16]), 8'h4A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
